spectrum_peak_search: RTL and testbench

- Downstream consumer of the windowed magnitude-squared spectrum stream.
- Receives selected FFT bins as non-negative IEEE-754 single values with their bin positions, and scans each frame for the maximum bin.
- Reports the peak value, the peak position, and the left and right neighbour values, for sub-bin interpolation and phase extraction.
- Sits between the bin-window selector and the phase/interpolation stage of the interferometer chain.

---
 rtl/spectrum_peak_search.sv | 183 ++++++++++++++++++
 tb/tb_spectrum_peak_search.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_search.sv
// rtl/spectrum_peak_search.sv - per-frame maximum-bin search with left/right neighbour capture
//
// Scans a stream of non-negative IEEE-754 single magnitude-squared bins per frame.
// The frame ends at the sample cycle flagged by frame_last. One cycle later it
// reports the peak bin, its position and the samples on either side of it in stream order.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   sel_data           selected bin value (sign bit ignored), qualified by sel_en
//   sel_en             sample strobe
//   sel_position       bin index of sel_data
//   frame_last         one-cycle end-of-frame pulse (may coincide with a sample)
//   peak_value         maximum bin value of the last completed frame
//   peak_position      bin index of peak_value
//   peak_left          sample before the peak, 0 if the peak was first
//   peak_right         sample after the peak, 0 if the peak was last
//   peak_valid         one-cycle pulse when the result registers update
//   frame_empty        result came from a frame with no samples
//   busy               a frame is in progress
//
// Optional build macro PEAK_SEARCH_THRESHOLD_EN adds:
//   peak_threshold     input, peak must exceed this key to count as found
//   peak_found         output, registered with peak_valid; position forced to 0 when clear

module spectrum_peak_search #(
    parameter int DATA_W = 32,
    parameter int POS_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sel_data,
    input  logic              sel_en,
    input  logic [POS_W-1:0]  sel_position,
    input  logic              frame_last,
`ifdef PEAK_SEARCH_THRESHOLD_EN
    input  logic [DATA_W-1:0] peak_threshold,
    output logic              peak_found,
`endif
    output logic [DATA_W-1:0] peak_value,
    output logic [POS_W-1:0]  peak_position,
    output logic [DATA_W-1:0] peak_left,
    output logic [DATA_W-1:0] peak_right,
    output logic              peak_valid,
    output logic              frame_empty,
    output logic              busy
);

    // Clearing the sign bit makes the unsigned integer order match float order.
    localparam logic [DATA_W-1:0] KEY_MASK  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [POS_W:0]    COUNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SEARCH, RIGHT} state_t;

    state_t            state, n_state;
    logic [DATA_W-1:0] cand_value, n_value;
    logic [POS_W-1:0]  cand_pos, n_pos;
    logic [DATA_W-1:0] cand_left, n_left;
    logic [DATA_W-1:0] cand_right, n_right;
    logic [DATA_W-1:0] prev, n_prev;
    logic [POS_W:0]    count, n_count;
    logic [DATA_W-1:0] sample;
    logic              greater;
    logic              empty_now;

    // Next candidate state including this cycle's sample; the frame_last cycle
    // reports from these values so the result appears with one cycle of latency.
    always_comb begin
        sample    = sel_data & KEY_MASK;
        greater   = sample > cand_value;
        n_state   = state;
        n_value   = cand_value;
        n_pos     = cand_pos;
        n_left    = cand_left;
        n_right   = cand_right;
        n_prev    = prev;
        n_count   = count;
        if (sel_en) begin
            n_prev = sample;
            if (count != COUNT_MAX) begin
                n_count = count + 1'b1;
            end
            case (state)
                IDLE: begin
                    n_value = sample;
                    n_pos   = sel_position;
                    n_left  = '0;
                    n_right = '0;
                    n_state = RIGHT;
                end
                SEARCH: begin
                    if (greater) begin
                        n_value = sample;
                        n_pos   = sel_position;
                        n_left  = prev;
                        n_state = RIGHT;
                    end
                end
                RIGHT: begin
                    // Strictly greater only: a tie keeps the earlier candidate.
                    if (greater) begin
                        n_value = sample;
                        n_pos   = sel_position;
                        n_left  = prev;
                    end else begin
                        n_right = sample;
                        n_state = SEARCH;
                    end
                end
                default: n_state = IDLE;
            endcase
        end
        empty_now = (count == '0) && !sel_en;
    end

`ifdef PEAK_SEARCH_THRESHOLD_EN
    logic found_now;
    assign found_now = !empty_now && (n_value > (peak_threshold & KEY_MASK));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cand_value    <= '0;
            cand_pos      <= '0;
            cand_left     <= '0;
            cand_right    <= '0;
            prev          <= '0;
            count         <= '0;
            peak_value    <= '0;
            peak_position <= '0;
            peak_left     <= '0;
            peak_right    <= '0;
            peak_valid    <= 1'b0;
            frame_empty   <= 1'b0;
            busy          <= 1'b0;
`ifdef PEAK_SEARCH_THRESHOLD_EN
            peak_found    <= 1'b0;
`endif
        end else begin
            peak_valid <= frame_last;
            if (frame_last) begin
                state      <= IDLE;
                cand_value <= '0;
                cand_pos   <= '0;
                cand_left  <= '0;
                cand_right <= '0;
                prev       <= '0;
                count      <= '0;
                busy       <= 1'b0;
                if (empty_now) begin
                    peak_value    <= '0;
                    peak_position <= '0;
                    peak_left     <= '0;
                    peak_right    <= '0;
                    frame_empty   <= 1'b1;
                end else begin
                    peak_value    <= n_value;
                    peak_position <= n_pos;
                    peak_left     <= n_left;
                    // Ending in RIGHT means the peak was the last sample.
                    peak_right    <= (n_state == RIGHT) ? '0 : n_right;
                    frame_empty   <= 1'b0;
                end
`ifdef PEAK_SEARCH_THRESHOLD_EN
                peak_found <= found_now;
                if (!found_now) begin
                    peak_position <= '0;
                end
`endif
            end else begin
                state      <= n_state;
                cand_value <= n_value;
                cand_pos   <= n_pos;
                cand_left  <= n_left;
                cand_right <= n_right;
                prev       <= n_prev;
                count      <= n_count;
                busy       <= (n_state != IDLE);
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_search.sv
// tb/tb_spectrum_peak_search.sv - directed scoreboard bench for spectrum_peak_search

module tb_spectrum_peak_search;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sel_data;
    logic        sel_en;
    logic [7:0]  sel_position;
    logic        frame_last;
    logic [31:0] peak_value;
    logic [7:0]  peak_position;
    logic [31:0] peak_left;
    logic [31:0] peak_right;
    logic        peak_valid;
    logic        frame_empty;
    logic        busy;
`ifdef PEAK_SEARCH_THRESHOLD_EN
    logic [31:0] peak_threshold = 32'h40A00000;
    logic        peak_found;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  pos;
        logic [31:0] left;
        logic [31:0] right;
        logic        empty;
        logic        found;
    } exp_t;

    exp_t exp_q[$];

    spectrum_peak_search #(.DATA_W(32), .POS_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel_data      (sel_data),
        .sel_en        (sel_en),
        .sel_position  (sel_position),
        .frame_last    (frame_last),
`ifdef PEAK_SEARCH_THRESHOLD_EN
        .peak_threshold(peak_threshold),
        .peak_found    (peak_found),
`endif
        .peak_value    (peak_value),
        .peak_position (peak_position),
        .peak_left     (peak_left),
        .peak_right    (peak_right),
        .peak_valid    (peak_valid),
        .frame_empty   (frame_empty),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void expect_frame(input logic [31:0] v, input logic [7:0] p,
                                         input logic [31:0] l, input logic [31:0] r,
                                         input logic e);
        exp_t x;
        x.value = v;
        x.pos   = p;
        x.left  = l;
        x.right = r;
        x.empty = e;
        x.found = 1'b0;
`ifdef PEAK_SEARCH_THRESHOLD_EN
        x.found = !e && ((v & 32'h7FFFFFFF) > (32'h40A00000 & 32'h7FFFFFFF));
        if (!x.found) x.pos = 8'd0;
`endif
        exp_q.push_back(x);
    endfunction

    // One clock; outputs sampled 1 time unit after the edge. want_pulse is the
    // frame_last value that edge consumed, so the result is due right now.
    task automatic tick(input logic want_pulse);
        exp_t x;
        @(posedge clk);
        #1;
        chk("peak_valid", {31'd0, peak_valid}, {31'd0, want_pulse});
        if (want_pulse) chk("busy_result_cycle", {31'd0, busy}, 32'd0);
        if (peak_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_result observed=pulse expected=none");
            end
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("peak_value", peak_value, x.value);
                chk("peak_position", {24'd0, peak_position}, {24'd0, x.pos});
                chk("peak_left", peak_left, x.left);
                chk("peak_right", peak_right, x.right);
                chk("frame_empty", {31'd0, frame_empty}, {31'd0, x.empty});
`ifdef PEAK_SEARCH_THRESHOLD_EN
                chk("peak_found", {31'd0, peak_found}, {31'd0, x.found});
`endif
            end
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] d, input logic [7:0] p,
                         input logic last);
        sel_en       = en;
        sel_data     = d;
        sel_position = p;
        frame_last   = last;
        tick(last);
        sel_en       = 1'b0;
        sel_data     = 32'd0;
        sel_position = 8'd0;
        frame_last   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_value"}, peak_value, 32'd0);
        chk({tag, "_position"}, {24'd0, peak_position}, 32'd0);
        chk({tag, "_left"}, peak_left, 32'd0);
        chk({tag, "_right"}, peak_right, 32'd0);
        chk({tag, "_valid"}, {31'd0, peak_valid}, 32'd0);
        chk({tag, "_empty"}, {31'd0, frame_empty}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        sel_en       = 1'b0;
        sel_data     = 32'd0;
        sel_position = 8'd0;
        frame_last   = 1'b0;
        tick(1'b0);
        tick(1'b0);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(1'b0);

        // Basic frame 1.0 3.0 7.0 2.0 0.5 at positions 10..14, with an idle gap
        drive(1'b1, 32'h3F800000, 8'd10, 1'b0);
        chk("busy_after_first", {31'd0, busy}, 32'd1);
        drive(1'b0, 32'h0, 8'd0, 1'b0);
        drive(1'b1, 32'h40400000, 8'd11, 1'b0);
        drive(1'b1, 32'h40E00000, 8'd12, 1'b0);
        drive(1'b1, 32'h40000000, 8'd13, 1'b0);
        expect_frame(32'h40E00000, 8'd12, 32'h40400000, 32'h40000000, 1'b0);
        drive(1'b1, 32'h3F000000, 8'd14, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 1'b0);
        chk("hold_value", peak_value, 32'h40E00000);

        // Empty frame
        expect_frame(32'd0, 8'd0, 32'd0, 32'd0, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 1'b0);
        chk("hold_empty", {31'd0, frame_empty}, 32'd1);

        // Peak first (9,1,2), back-to-back into peak last (1,2,9), then an aborted frame
        drive(1'b1, 32'h41100000, 8'd0, 1'b0);
        drive(1'b1, 32'h3F800000, 8'd1, 1'b0);
        expect_frame(32'h41100000, 8'd0, 32'd0, 32'h3F800000, 1'b0);
        drive(1'b1, 32'h40000000, 8'd2, 1'b1);
        drive(1'b1, 32'h3F800000, 8'd30, 1'b0);
        drive(1'b1, 32'h40000000, 8'd31, 1'b0);
        expect_frame(32'h41100000, 8'd32, 32'h40000000, 32'd0, 1'b0);
        drive(1'b1, 32'h41100000, 8'd32, 1'b1);
        drive(1'b1, 32'h40A00000, 8'd40, 1'b0);
        drive(1'b1, 32'h40C00000, 8'd41, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick(1'b0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 8'd0, 1'b0);
        drive(1'b0, 32'h0, 8'd0, 1'b0);

        // Tie: first 4.0 at position 20 wins, right neighbour is position 21
        drive(1'b1, 32'h40800000, 8'd20, 1'b0);
        drive(1'b1, 32'h3F800000, 8'd21, 1'b0);
        expect_frame(32'h40800000, 8'd20, 32'd0, 32'h3F800000, 1'b0);
        drive(1'b1, 32'h40800000, 8'd25, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 1'b0);

        // Sign bit ignored and stored cleared; exponent 0xFF is the largest key
        drive(1'b1, 32'h40000000, 8'd5, 1'b0);
        drive(1'b1, 32'hC1200000, 8'd6, 1'b0);
        drive(1'b1, 32'h7F800000, 8'd7, 1'b0);
        expect_frame(32'h7F800000, 8'd7, 32'h41200000, 32'h3F800000, 1'b0);
        drive(1'b1, 32'h3F800000, 8'd8, 1'b1);

        // Single-sample frame straight from IDLE, back-to-back
        expect_frame(32'h40400000, 8'd50, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 32'h40400000, 8'd50, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 1'b0);
        drive(1'b0, 32'h0, 8'd0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
